// File: rtl/bcd_scan_driver.sv
// Time-multiplexed 4-position 7-segment driver for a 12-bit BCD value.
// The value is snapshotted once per frame; a guard gap precedes every digit slot.
module bcd_scan_driver #(
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 8,
  parameter int LZ_BLANK     = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  typedef enum logic {GUARD, DRIVE} state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH-1:0] GUARD_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [3:0]           AN_OFF     = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [6:0]           SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [11:0]          snap_q, snap_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 tick_q, tick_d;
  logic [3:0]           nib;
  logic                 blank;
  logic                 lit;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + DIV_WIDTH'(1);
    unique case (state_q)
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DIV_LAST) begin
          state_d = GUARD;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
    endcase
  end

  // Decode uses snap_d so a slot entered on the boundary edge already sees the new frame.
  always_comb begin
    tick_d = (state_q == GUARD) && (idx_q == 2'd0) && (cnt_q == '0);
    snap_d = tick_d ? bcd_in : snap_q;
    nib    = 4'h0;
    blank  = 1'b0;
    case (idx_d)
      2'd0: nib = snap_d[3:0];
      2'd1: begin
        nib   = snap_d[7:4];
        blank = (LZ_BLANK != 0) && (snap_d[11:4] == 8'h00);
      end
      2'd2: begin
        nib   = snap_d[11:8];
        blank = (LZ_BLANK != 0) && (snap_d[11:8] == 4'h0);
      end
      default: blank = 1'b1;
    endcase
    lit   = (state_d == DRIVE) && !blank;
    an_d  = lit ? ((4'b0001 << idx_d) ^ AN_OFF) : AN_OFF;
    seg_d = lit ? (hex7(nib) ^ SEG_OFF) : SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GUARD;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      snap_q  <= 12'h000;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule
